// File: rtl/mc_op_scheduler_if.sv
// EX-stage <-> multi-cycle scheduler signal bundle.
// MC_SCHED_PERF_EN adds the performance counter outputs.
interface mc_op_scheduler_if;
  logic        ex_valid;
  logic        op_mul;
  logic        op_div;
  logic        op_float;
  logic        flush;
  logic        stall;
  logic        unit_start;
  logic [1:0]  unit_sel;
  logic        result_valid;
  logic        busy;
`ifdef MC_SCHED_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_ops;
`endif

  modport master (
    output ex_valid, op_mul, op_div, op_float, flush,
    input  stall, unit_start, unit_sel, result_valid, busy
`ifdef MC_SCHED_PERF_EN
    , input perf_stall_cycles, perf_ops
`endif
  );

  modport slave (
    input  ex_valid, op_mul, op_div, op_float, flush,
    output stall, unit_start, unit_sel, result_valid, busy
`ifdef MC_SCHED_PERF_EN
    , output perf_stall_cycles, perf_ops
`endif
  );
endinterface

// File: rtl/mc_op_scheduler.sv
// One-in-flight sequencer for the mul/div/float execute units in EX.
// Optional feature macro: MC_SCHED_PERF_EN (stall-cycle and issued-op counters).
module mc_op_scheduler #(
  parameter int MUL_LAT = 6,
  parameter int DIV_LAT = 32,
  parameter int FLT_LAT = 32,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  mc_op_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_MUL  = 2'd1,
    SEL_DIV  = 2'd2,
    SEL_FLT  = 2'd3
  } sel_e;

  state_e           state;
  sel_e             sel_q;
  sel_e             req_sel;
  sel_e             unit_sel;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] last_cnt;
  logic             req;
  logic             stall;
  logic             unit_start;
  logic             result_valid;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_sel = SEL_NONE;
    if (bus.op_mul)        req_sel = SEL_MUL;
    else if (bus.op_div)   req_sel = SEL_DIV;
    else if (bus.op_float) req_sel = SEL_FLT;
  end

  assign req = bus.ex_valid & ~bus.flush & (req_sel != SEL_NONE);

  always_comb begin
    last_cnt = CNT_W'(MUL_LAT - 1);
    case (sel_q)
      SEL_DIV: last_cnt = CNT_W'(DIV_LAT - 1);
      SEL_FLT: last_cnt = CNT_W'(FLT_LAT - 1);
      default: last_cnt = CNT_W'(MUL_LAT - 1);
    endcase
  end

  // Issue is visible in the same cycle so the front end holds on T0.
  always_comb begin
    stall        = 1'b0;
    unit_start   = 1'b0;
    unit_sel     = SEL_NONE;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        stall      = req;
        unit_start = req;
        unit_sel   = req ? req_sel : SEL_NONE;
      end
      BUSY: begin
        stall    = ~bus.flush;
        unit_sel = sel_q;
      end
      DONE: begin
        result_valid = ~bus.flush;
        unit_sel     = sel_q;
      end
      default: ;
    endcase
    // Held reset must silence the combinational issue path as well.
    if (rst) begin
      stall        = 1'b0;
      unit_start   = 1'b0;
      unit_sel     = SEL_NONE;
      result_valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      sel_q <= SEL_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            sel_q <= req_sel;
            count <= CNT_W'(1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state <= IDLE;
            count <= '0;
            sel_q <= SEL_NONE;
          end else if (count == last_cnt) begin
            state <= DONE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          // Any req seen here is the retiring instruction itself.
          state <= IDLE;
          count <= '0;
          sel_q <= SEL_NONE;
        end
        default: begin
          state <= IDLE;
          count <= '0;
          sel_q <= SEL_NONE;
        end
      endcase
    end
  end

  assign bus.stall        = stall;
  assign bus.unit_start   = unit_start;
  assign bus.unit_sel     = unit_sel;
  assign bus.result_valid = result_valid;
  assign bus.busy         = (state != IDLE);

`ifdef MC_SCHED_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_ops_q;

  // Free-running counters; wrap at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_ops_q   <= '0;
    end else begin
      if (stall)      perf_stall_q <= perf_stall_q + 32'd1;
      if (unit_start) perf_ops_q   <= perf_ops_q + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_ops          = perf_ops_q;
`endif

endmodule

// File: tb/tb_mc_op_scheduler.sv
// Self-checking bench for mc_op_scheduler: per-scenario cycle checks plus a
// result scoreboard keyed on unit_sel and the retire cycle.
module tb_mc_op_scheduler;
  localparam int MUL_LAT = 6;
  localparam int DIV_LAT = 32;
  localparam int FLT_LAT = 32;

  logic clk;
  logic rst;

  mc_op_scheduler_if bus();

  mc_op_scheduler #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .FLT_LAT(FLT_LAT),
    .CNT_W  (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [1:0] sel;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   exp_stall_acc = 0;
  int   exp_ops_acc = 0;

  // {stall, unit_start, unit_sel, result_valid, busy}
  logic [5:0] obs;
  assign obs = {bus.stall, bus.unit_start, bus.unit_sel, bus.result_valid, bus.busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] ev(input logic s, input logic st, input logic [1:0] sel,
                                    input logic rv, input logic b);
    return {s, st, sel, rv, b};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_inputs();
    bus.ex_valid = 1'b0;
    bus.op_mul   = 1'b0;
    bus.op_div   = 1'b0;
    bus.op_float = 1'b0;
    bus.flush    = 1'b0;
  endtask

  // Scoreboard: every result_valid must match the oldest pending op.
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_spurious: result_valid at cycle %0d, no op pending", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (bus.unit_sel !== mon_e.sel || cyc != mon_e.due)
          $display("FAIL sb_result: got sel=%0d cycle=%0d, want sel=%0d cycle=%0d",
                   bus.unit_sel, cyc, mon_e.sel, mon_e.due);
        else
          passes++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    drop_inputs();
    #12;
    checks++;
    if (obs !== 6'b0) $display("FAIL reset_idle: got %b want %b", obs, 6'b0);
    else passes++;
    bus.ex_valid = 1'b1;
    bus.op_mul   = 1'b1;
    #1;
    checks++;
    if (obs !== 6'b0) $display("FAIL reset_gates_req: got %b want %b", obs, 6'b0);
    else passes++;
    drop_inputs();
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) $display("FAIL reset_release: got %b want %b", obs, 6'b0);
    else passes++;
  endtask

  task automatic test_mid_reset();
    logic [5:0] e;
    next_cycle();
    bus.ex_valid = 1'b1;
    bus.op_div   = 1'b1;
    sb.push_back('{2'd2, cyc + DIV_LAT});
    for (int t = 0; t < 15; t++) begin
      if (t > 0) next_cycle();
      e = ev(1'b1, t == 0, 2'd2, 1'b0, t > 0);
      @(negedge clk);
      checks++;
      if (obs !== e) $display("FAIL mid_reset_run t=%0d: got %b want %b", t, obs, e);
      else passes++;
    end
    next_cycle();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 6'b0) $display("FAIL mid_reset_async: got %b want %b", obs, 6'b0);
    else passes++;
    drop_inputs();
    #1 rst = 1'b0;
    void'(sb.pop_back());
    exp_stall_acc = 0;
    exp_ops_acc   = 0;
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) $display("FAIL mid_reset_after: got %b want %b", obs, 6'b0);
    else passes++;
    next_cycle();
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) $display("FAIL mid_reset_idle: got %b want %b", obs, 6'b0);
    else passes++;
  endtask

  task automatic run_single(input string name, input logic m, input logic d, input logic f,
                            input logic [1:0] sel, input int lat);
    logic [5:0] e;
    next_cycle();
    bus.ex_valid = 1'b1;
    bus.op_mul   = m;
    bus.op_div   = d;
    bus.op_float = f;
    sb.push_back('{sel, cyc + lat});
    for (int t = 0; t <= lat; t++) begin
      if (t > 0) next_cycle();
      e = ev(t < lat, t == 0, sel, t == lat, t > 0);
      @(negedge clk);
      checks++;
      if (obs !== e) $display("FAIL %s t=%0d: got %b want %b", name, t, obs, e);
      else passes++;
      exp_stall_acc += int'(e[5]);
      exp_ops_acc   += int'(e[4]);
    end
    next_cycle();
    drop_inputs();
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) $display("FAIL %s_after: got %b want %b", name, obs, 6'b0);
    else passes++;
  endtask

  task automatic test_mul();
    run_single("mul", 1'b1, 1'b0, 1'b0, 2'd1, MUL_LAT);
  endtask

  task automatic test_priority();
    run_single("priority", 1'b1, 1'b1, 1'b1, 2'd1, MUL_LAT);
  endtask

  task automatic test_back_to_back();
    localparam int I2 = DIV_LAT + 1;
    logic [5:0] e;
    next_cycle();
    bus.ex_valid = 1'b1;
    bus.op_div   = 1'b1;
    sb.push_back('{2'd2, cyc + DIV_LAT});
    for (int t = 0; t <= I2 + MUL_LAT; t++) begin
      if (t > 0) next_cycle();
      if (t == I2) begin
        bus.op_div = 1'b0;
        bus.op_mul = 1'b1;
        sb.push_back('{2'd1, cyc + MUL_LAT});
      end
      e = ev((t < DIV_LAT) || (t >= I2 && t < I2 + MUL_LAT),
             (t == 0) || (t == I2),
             (t < I2) ? 2'd2 : 2'd1,
             (t == DIV_LAT) || (t == I2 + MUL_LAT),
             (t > 0 && t <= DIV_LAT) || (t > I2 && t <= I2 + MUL_LAT));
      @(negedge clk);
      checks++;
      if (obs !== e) $display("FAIL back_to_back t=%0d: got %b want %b", t, obs, e);
      else passes++;
      exp_stall_acc += int'(e[5]);
      exp_ops_acc   += int'(e[4]);
    end
    next_cycle();
    drop_inputs();
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) $display("FAIL back_to_back_after: got %b want %b", obs, 6'b0);
    else passes++;
  endtask

  task automatic test_flush();
    localparam int F  = 10;
    localparam int I2 = 11;
    logic [5:0] e;
    next_cycle();
    bus.ex_valid = 1'b1;
    bus.op_div   = 1'b1;
    bus.op_float = 1'b1;
    sb.push_back('{2'd2, cyc + DIV_LAT});
    for (int t = 0; t <= I2 + FLT_LAT; t++) begin
      if (t > 0) next_cycle();
      if (t == F) begin
        bus.flush = 1'b1;
        void'(sb.pop_back());
      end
      if (t == I2) begin
        bus.flush  = 1'b0;
        bus.op_div = 1'b0;
        sb.push_back('{2'd3, cyc + FLT_LAT});
      end
      if (t == I2 + 1) begin
        bus.ex_valid = 1'b0;
        bus.op_float = 1'b0;
      end
      if (t == 20) begin
        bus.ex_valid = 1'b1;
        bus.op_mul   = 1'b1;
      end
      e = ev((t < F) || (t >= I2 && t < I2 + FLT_LAT),
             (t == 0) || (t == I2),
             (t < I2) ? 2'd2 : 2'd3,
             t == I2 + FLT_LAT,
             (t > 0 && t <= F) || (t > I2 && t <= I2 + FLT_LAT));
      @(negedge clk);
      checks++;
      if (obs !== e) $display("FAIL flush t=%0d: got %b want %b", t, obs, e);
      else passes++;
      exp_stall_acc += int'(e[5]);
      exp_ops_acc   += int'(e[4]);
    end
    next_cycle();
    drop_inputs();
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) $display("FAIL flush_after: got %b want %b", obs, 6'b0);
    else passes++;
  endtask

  task automatic test_flush_idle();
    next_cycle();
    bus.ex_valid = 1'b1;
    bus.op_div   = 1'b1;
    bus.flush    = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) $display("FAIL flush_idle_t0: got %b want %b", obs, 6'b0);
    else passes++;
    next_cycle();
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) $display("FAIL flush_idle_t1: got %b want %b", obs, 6'b0);
    else passes++;
    drop_inputs();
  endtask

`ifdef MC_SCHED_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    checks++;
    if (bus.perf_ops !== 32'(exp_ops_acc))
      $display("FAIL perf_ops: got %0d want %0d", bus.perf_ops, exp_ops_acc);
    else passes++;
    checks++;
    if (bus.perf_stall_cycles !== 32'(exp_stall_acc))
      $display("FAIL perf_stall_cycles: got %0d want %0d", bus.perf_stall_cycles, exp_stall_acc);
    else passes++;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passes);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drop_inputs();
    test_reset();
    test_mid_reset();
    test_mul();
    test_priority();
    test_back_to_back();
    test_flush();
    test_flush_idle();
`ifdef MC_SCHED_PERF_EN
    test_perf();
`endif
    next_cycle();
    checks++;
    if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
